// File: rtl/kf8237_transfer_sequencer_pkg.sv
//==============================================================================
// Module      : kf8237_transfer_sequencer_pkg
// Description : Shared types and helpers for the KF8237 transfer sequencer:
//               transfer-state enumeration, per-channel transfer mode codes,
//               one-hot/index channel conversion and mode-field extraction.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package kf8237_transfer_sequencer_pkg;

   // Transfer cycle states: idle, hold wait, S1..S3, ready wait, S4.
   typedef enum logic [2:0] {
      SI = 3'd0,
      S0 = 3'd1,
      S1 = 3'd2,
      S2 = 3'd3,
      S3 = 3'd4,
      SW = 3'd5,
      S4 = 3'd6
   } dma_state_t;

   // Per-channel transfer mode field encodings.
   localparam logic [1:0] DEMAND  = 2'b00;
   localparam logic [1:0] SINGLE  = 2'b01;
   localparam logic [1:0] BLOCK   = 2'b10;
   localparam logic [1:0] CASCADE = 2'b11;

   // One-hot channel to 2-bit index; the highest set bit wins, which never
   // matters for a well-formed one-hot input.
   function automatic logic [1:0] onehot_to_index(input logic [3:0] onehot);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (onehot[i]) idx = i[1:0];
      end
      return idx;
   endfunction

   function automatic logic [3:0] index_to_onehot(input logic [1:0] idx);
      return 4'b0001 << idx;
   endfunction

   // Extract the 2-bit mode field of channel ch from the packed mode vector.
   function automatic logic [1:0] channel_mode(input logic [7:0] modes,
                                               input logic [1:0] ch);
      logic [1:0] m;
      case (ch)
         2'd0:    m = modes[1:0];
         2'd1:    m = modes[3:2];
         2'd2:    m = modes[5:4];
         default: m = modes[7:6];
      endcase
      return m;
   endfunction

endpackage

`default_nettype wire

// File: rtl/kf8237_transfer_sequencer.sv
//==============================================================================
// Module      : kf8237_transfer_sequencer
// Description : KF8237 DMA transfer sequencer. Accepts the one-hot winning
//               channel from the priority encoder, runs the HRQ/HLDA hold
//               handshake and the S1-S4 transfer cycle, and drives DACK, the
//               address/count advance strobe, internal EOP and the rotating
//               priority pointer. All registers update on the falling edge.
//
// Ports       : clock, reset (async, active-high), master_clear (sync clear)
//               encoded_dma[3:0]   one-hot winning request (0 = none)
//               dreq_active[3:0]   masked raw requests (demand/cascade hold)
//               transfer_mode[7:0] 2 bits/channel: 00 dem 01 sgl 10 blk 11 cas
//               hold_acknowledge, ready, terminal_count, external_eop
//               hold_request, dma_acknowledge_internal[3:0], advance_address,
//               end_of_process, dma_rotate[1:0], transfer_active
//
// Config      : KF8237_READY_WAIT_EN - when defined, ready is sampled in S3/SW
//               and ready=0 inserts SW wait states; otherwise ready is ignored.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module kf8237_transfer_sequencer
   import kf8237_transfer_sequencer_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       master_clear,
   input  logic [3:0] encoded_dma,
   input  logic [3:0] dreq_active,
   input  logic [7:0] transfer_mode,
   input  logic       hold_acknowledge,
   input  logic       ready,
   input  logic       terminal_count,
   input  logic       external_eop,
   output logic       hold_request,
   output logic [3:0] dma_acknowledge_internal,
   output logic       advance_address,
   output logic       end_of_process,
   output logic [1:0] dma_rotate,
   output logic       transfer_active
);

   dma_state_t r_state;
   dma_state_t w_next;

   logic [1:0] r_channel;      // channel in service, latched at HLDA
   logic       r_eop_sticky;   // external EOP seen earlier in this transfer
   logic [1:0] r_rotate;

   logic [1:0] w_mode;
   logic       w_service;
   logic       w_last;
   logic       w_chan_req;

   assign w_mode     = channel_mode(transfer_mode, r_channel);
   assign w_chan_req = dreq_active[r_channel];
   assign w_service  = (r_state == S1) || (r_state == S2) || (r_state == S3) ||
                       (r_state == SW) || (r_state == S4);
   // In S4 an EOP request on the current clock counts as well as one
   // captured earlier in the transfer.
   assign w_last     = terminal_count | r_eop_sticky | external_eop;

`ifndef KF8237_READY_WAIT_EN
   logic w_unused_ready;
   assign w_unused_ready = ready;
`endif

   //---------------------------------------------------------------------------
   // State register
   //---------------------------------------------------------------------------
   always_ff @(negedge clock or posedge reset) begin
      if (reset) begin
         r_state <= SI;
      end else if (master_clear) begin
         r_state <= SI;
      end else begin
         r_state <= w_next;
      end
   end

   //---------------------------------------------------------------------------
   // Service channel, sticky EOP and rotate pointer
   //---------------------------------------------------------------------------
   always_ff @(negedge clock or posedge reset) begin
      if (reset) begin
         r_channel    <= 2'd0;
         r_eop_sticky <= 1'b0;
         r_rotate     <= 2'd0;
      end else if (master_clear) begin
         r_channel    <= 2'd0;
         r_eop_sticky <= 1'b0;
         r_rotate     <= 2'd0;
      end else begin
         if ((r_state == S0) && hold_acknowledge && (encoded_dma != 4'd0)) begin
            r_channel <= onehot_to_index(encoded_dma);
         end
         // Capture EOP up to S4; S4 consumes it directly, so clear there.
         if (w_service && (r_state != S4)) begin
            r_eop_sticky <= r_eop_sticky | external_eop;
         end else begin
            r_eop_sticky <= 1'b0;
         end
         // Serviced channel drops to lowest priority on return to idle.
         if (w_service && (w_next == SI)) begin
            r_rotate <= r_channel + 2'd1;
         end
      end
   end

   //---------------------------------------------------------------------------
   // Next-state logic
   //---------------------------------------------------------------------------
   always_comb begin
      w_next = r_state;
      case (r_state)
         SI: begin
            if (encoded_dma != 4'd0) w_next = S0;
         end
         S0: begin
            if (hold_acknowledge) begin
               w_next = (encoded_dma != 4'd0) ? S1 : SI;
            end
         end
         S1: begin
            if (w_mode == CASCADE) begin
               w_next = w_chan_req ? S1 : SI;
            end else begin
               w_next = S2;
            end
         end
         S2: w_next = S3;
`ifdef KF8237_READY_WAIT_EN
         S3: w_next = ready ? S4 : SW;
         SW: w_next = ready ? S4 : SW;
`else
         S3: w_next = S4;
         SW: w_next = S4;
`endif
         S4: begin
            if (w_last) begin
               w_next = SI;
            end else begin
               case (w_mode)
                  BLOCK:   w_next = S1;
                  DEMAND:  w_next = w_chan_req ? S1 : SI;
                  default: w_next = SI;
               endcase
            end
         end
         default: w_next = SI;
      endcase
   end

   //---------------------------------------------------------------------------
   // Output decode
   //---------------------------------------------------------------------------
   always_comb begin
      hold_request             = 1'b0;
      dma_acknowledge_internal = 4'd0;
      advance_address          = 1'b0;
      end_of_process           = 1'b0;
      transfer_active          = 1'b0;
      case (r_state)
         S0: hold_request = 1'b1;
         S1, S2, S3, SW: begin
            hold_request             = 1'b1;
            transfer_active          = 1'b1;
            dma_acknowledge_internal = index_to_onehot(r_channel);
         end
         S4: begin
            hold_request             = 1'b1;
            transfer_active          = 1'b1;
            dma_acknowledge_internal = index_to_onehot(r_channel);
            advance_address          = 1'b1;
            end_of_process           = w_last;
         end
         default: ;
      endcase
   end

   assign dma_rotate = r_rotate;

endmodule

`default_nettype wire
